interval_timer_bank: RTL and testbench

//   Parametrised, multi-channel millisecond timer for the game control logic.
//   One shared prescaler produces a base tick every CLK_HZ/TICK_HZ clocks.
//   NUM_CH independent channels count base ticks down from a loaded value and

---
 rtl/interval_timer_bank.sv | 122 ++++++++++++
 tb/tb_interval_timer_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_bank
// Purpose  : One shared prescaler that produces a base tick every
//            CLK_HZ/TICK_HZ clocks. It drives NUM_CH independent down-counting
//            channels. Each channel runs in one-shot or periodic mode and
//            emits a one-cycle timeout pulse when it expires.
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_bank #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    output logic                    tick,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       busy
);

    localparam int c_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    localparam logic [c_PW-1:0]  c_PRE_LAST = c_PW'(c_DIV - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [c_PW-1:0] r_pre;
    logic            r_tick;

    // Shared prescaler: wraps every c_DIV enabled clocks and flags the wrap
    // with a registered one-cycle tick; frozen, with tick low, while disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            if (r_pre == c_PRE_LAST) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + c_PW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [0:0]       r_state;
            logic [CNT_W-1:0] r_count;
            logic [CNT_W-1:0] r_reload;
            logic             r_mode;
            logic             r_timeout;
            logic [CNT_W-1:0] w_load;

            assign w_load = load_val[i*CNT_W +: CNT_W];

            // Channel state machine. stop beats start, and start beats the
            // tick decrement, so a retrigger on an expiring tick swallows
            // that expiry. A zero load expires immediately without running.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_state   <= c_ST_IDLE;
                    r_count   <= '0;
                    r_reload  <= '0;
                    r_mode    <= 1'b0;
                    r_timeout <= 1'b0;
                end else if (stop[i]) begin
                    r_state   <= c_ST_IDLE;
                    r_count   <= '0;
                    r_timeout <= 1'b0;
                end else if (start[i]) begin
                    r_reload <= w_load;
                    r_mode   <= mode[i];
                    if (w_load != '0) begin
                        r_count   <= w_load;
                        r_state   <= c_ST_RUN;
                        r_timeout <= 1'b0;
                    end else begin
                        r_count   <= '0;
                        r_state   <= c_ST_IDLE;
                        r_timeout <= 1'b1;
                    end
                end else begin
                    r_timeout <= 1'b0;
                    if (r_state == c_ST_RUN && r_tick) begin
                        if (r_count != c_CNT_ONE) begin
                            r_count <= r_count - c_CNT_ONE;
                        end else begin
                            r_timeout <= 1'b1;
                            if (r_mode) begin
                                r_count <= r_reload;
                            end else begin
                                r_count <= '0;
                                r_state <= c_ST_IDLE;
                            end
                        end
                    end
                end
            end

            assign timeout[i] = r_timeout;
            assign busy[i]    = (r_state == c_ST_RUN);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_interval_timer_bank
// Purpose  : Directed bench for interval_timer_bank (DIV=10, 2 channels).
//            Expected timeout pulses are queued as (edge, channel) when
//            stimulus is applied and are consumed by a per-cycle monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interval_timer_bank;

    localparam int c_NCH = 2;
    localparam int c_CW  = 8;
    localparam int c_DIV = 10;

    logic                   clk;
    logic                   rst;
    logic                   enable;
    logic [c_NCH-1:0]       start;
    logic [c_NCH-1:0]       stop;
    logic [c_NCH-1:0]       mode;
    logic [c_NCH*c_CW-1:0]  load_val;
    logic                   tick;
    logic [c_NCH-1:0]       timeout;
    logic [c_NCH-1:0]       busy;

    interval_timer_bank #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .NUM_CH  (c_NCH),
        .CNT_W   (c_CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .tick     (tick),
        .timeout  (timeout),
        .busy     (busy)
    );

    typedef struct {
        int cyc;
        int ch;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         tick_ref = 0;
    logic       mon_on = 1'b0;
    logic [c_NCH-1:0] mon_exp;
    ev_t        mon_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    // Insert an expected pulse keeping the queue ordered by edge.
    task automatic push_exp(input int c, input int ch);
        ev_t e;
        int  pos;
        e.cyc = c;
        e.ch  = ch;
        pos   = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (c < sb[i].cyc) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    // First edge >= e after which tick is visible.
    function automatic int next_tick(input int e);
        int d;
        d = e - tick_ref;
        if (d <= 0) return tick_ref;
        return tick_ref + ((d + c_DIV - 1) / c_DIV) * c_DIV;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_ch(input int ch, input logic m, input int l, output int s);
        start[ch] = 1'b1;
        mode[ch]  = m;
        load_val[ch*c_CW +: c_CW] = l[c_CW-1:0];
        s = cyc + 1;
        @(negedge clk);
        start[ch] = 1'b0;
    endtask

    // Monitor: every cycle, timeout must equal exactly the pulses queued
    // for this edge.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_exp = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_ev = sb.pop_front();
                if (mon_ev.cyc == cyc) mon_exp[mon_ev.ch] = 1'b1;
            end
            chk("timeout", 32'(timeout), 32'(mon_exp));
        end
    end

    initial begin
        int s;
        int t;
        int te;
        int first;
        int r;

        rst      = 1'b0;
        enable   = 1'b0;
        start    = '0;
        stop     = '0;
        mode     = '0;
        load_val = '0;

        // 1: reset, prescaler period, freeze while disabled
        repeat (3) @(negedge clk);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        mon_on = 1'b1;
        rst    = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("tick_period", 32'(tick), (k % c_DIV == 0) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            chk("tick_frozen", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("tick_resume", 32'(tick), (k == 10) ? 32'd1 : 32'd0);
        end
        tick_ref = cyc;

        // 2: one-shot load 3 on ch0
        start_ch(0, 1'b0, 3, s);
        chk("os_busy_rise", 32'(busy[0]), 32'd1);
        te = next_tick(s) + 2 * c_DIV + 1;
        push_exp(te, 0);
        wait_until(te - 1);
        chk("os_busy_hold", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("os_busy_fall", 32'(busy[0]), 32'd0);
        repeat (100) @(negedge clk);
        chk("os_idle", 32'(busy[0]), 32'd0);

        // 3: periodic load 2 on ch1, five periods, then stop
        start_ch(1, 1'b1, 2, s);
        first = next_tick(s) + c_DIV + 1;
        for (int k = 0; k < 5; k++) push_exp(first + k * 2 * c_DIV, 1);
        wait_until(first + 4 * 2 * c_DIV);
        chk("per_busy", 32'(busy[1]), 32'd1);
        stop[1] = 1'b1;
        @(negedge clk);
        stop[1] = 1'b0;
        chk("per_stop_busy", 32'(busy[1]), 32'd0);
        repeat (60) @(negedge clk);

        // 4: stop and retrigger on the expiring tick
        start[0] = 1'b1; mode[0] = 1'b0; load_val[0 +: c_CW] = 8'd1;
        start[1] = 1'b1; mode[1] = 1'b1; load_val[c_CW +: c_CW] = 8'd1;
        @(negedge clk);
        start = '0;
        t = next_tick(cyc);
        wait_until(t);
        chk("race_tick", 32'(tick), 32'd1);
        stop[0]  = 1'b1;
        start[1] = 1'b1; mode[1] = 1'b1; load_val[c_CW +: c_CW] = 8'd3;
        push_exp(t + 3 * c_DIV + 1, 1);
        @(negedge clk);
        stop  = '0;
        start = '0;
        chk("race_stop_busy", 32'(busy[0]), 32'd0);
        chk("race_retrig_busy", 32'(busy[1]), 32'd1);
        wait_until(t + 3 * c_DIV + 1);
        chk("race_reload_busy", 32'(busy[1]), 32'd1);
        stop[1] = 1'b1;
        @(negedge clk);
        stop[1] = 1'b0;
        chk("race_stop1_busy", 32'(busy[1]), 32'd0);
        repeat (10) @(negedge clk);

        // 5: zero load expires immediately in both modes
        push_exp(cyc + 1, 0);
        start_ch(0, 1'b0, 0, s);
        chk("zero_os_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("zero_os_busy2", 32'(busy[0]), 32'd0);
        push_exp(cyc + 1, 1);
        start_ch(1, 1'b1, 0, s);
        chk("zero_per_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        chk("zero_per_busy2", 32'(busy[1]), 32'd0);
        repeat (5) @(negedge clk);

        // 6: reset mid-run on the edge both channels would expire
        start[0] = 1'b1; mode[0] = 1'b1; load_val[0 +: c_CW] = 8'd1;
        start[1] = 1'b1; mode[1] = 1'b1; load_val[c_CW +: c_CW] = 8'd1;
        s = cyc + 1;
        @(negedge clk);
        start = '0;
        t = next_tick(s);
        push_exp(t + 1, 0);
        push_exp(t + 1, 1);
        push_exp(t + c_DIV + 1, 0);
        push_exp(t + c_DIV + 1, 1);
        wait_until(t + 2 * c_DIV);
        chk("mid_tick", 32'(tick), 32'd1);
        chk("mid_busy", 32'(busy), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        r = cyc;
        tick_ref = r + c_DIV;
        repeat (50) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        start_ch(0, 1'b0, 2, s);
        te = next_tick(s) + c_DIV + 1;
        push_exp(te, 0);
        wait_until(te);
        chk("restart_busy", 32'(busy[0]), 32'd0);
        repeat (5) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
